// File: rtl/alarm_unit.sv
// alarm_unit: multi-channel BCD hh:mm alarm controller with ring timeout and
// optional snooze. The macro ALARM_SNOOZE_EN enables the snooze input, the
// SNOOZE state and the MAX_SNOOZE limit; without it the FSM is IDLE/RING only.
module alarm_unit #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  localparam int unsigned IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  cp,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic [23:0]           hms,
  input  logic                  tone_in,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [15:0]           wr_hm,
  input  logic                  wr_on,
  input  logic                  stop,
  input  logic                  snooze,
  output logic                  alarm,
  output logic                  ringing,
  output logic                  snoozing,
  output logic [IDXW-1:0]       active_idx,
  output logic [NUM_ALARMS-1:0] alarm_on
);

  localparam int unsigned SNZ_SECS = SNOOZE_MIN * 60;
  localparam int unsigned SECS_MAX = (RING_SECS > SNZ_SECS) ? RING_SECS : SNZ_SECS;
  localparam int unsigned SW       = $clog2(SECS_MAX + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t          state;
  logic [SW-1:0]   secs;
  logic [15:0]     hm [NUM_ALARMS];
  logic            hit;
  logic [IDXW-1:0] hit_idx;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  logic [CW-1:0] snz_cnt;
  logic          snz_q;
  logic          snz_edge;

  assign snz_edge = snooze & ~snz_q;

  // Previous snooze level for rising-edge detection
  always_ff @(posedge cp or posedge rst) begin
    if (rst) snz_q <= 1'b0;
    else     snz_q <= snooze;
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ (MAX_SNOOZE != 0);
  assign snoozing      = 1'b0;
`endif

  // Alarm setting registers; out-of-range indices match no channel
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      alarm_on <= '0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) hm[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (wr_idx == IDXW'(i)) begin
          hm[i]       <= wr_hm;
          alarm_on[i] <= wr_on;
        end
      end
    end
  end

  // Per-channel match on the second tick at ss=00, lowest index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (!hit && alarm_on[i] && sec_tick && (hms == {hm[i], 8'h00})) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  // Ring / snooze state machine with registered status outputs
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ringing    <= 1'b0;
      active_idx <= '0;
      secs       <= '0;
`ifdef ALARM_SNOOZE_EN
      snoozing   <= 1'b0;
      snz_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!stop && hit) begin
            state      <= RING;
            ringing    <= 1'b1;
            active_idx <= hit_idx;
            secs       <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt    <= '0;
`endif
          end
        end
        RING: begin
          if (stop) begin
            state   <= IDLE;
            ringing <= 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snz_edge) begin
            ringing <= 1'b0;
            if (snz_cnt < CW'(MAX_SNOOZE)) begin
              state    <= SNOOZE;
              snoozing <= 1'b1;
              secs     <= '0;
              snz_cnt  <= snz_cnt + 1'b1;
            end else begin
              state <= IDLE;
            end
          end
`endif
          else if (sec_tick) begin
            if (secs == SW'(RING_SECS - 1)) begin
              state   <= IDLE;
              ringing <= 1'b0;
            end else begin
              secs <= secs + 1'b1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (sec_tick && (secs == SW'(SNZ_SECS - 1))) begin
            state    <= RING;
            ringing  <= 1'b1;
            snoozing <= 1'b0;
            secs     <= '0;
          end else if (hit) begin
            // a fresh alarm preempts the snooze and restarts the snooze budget
            state      <= RING;
            ringing    <= 1'b1;
            snoozing   <= 1'b0;
            active_idx <= hit_idx;
            secs       <= '0;
            snz_cnt    <= '0;
          end else if (sec_tick) begin
            secs <= secs + 1'b1;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          snoozing <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign alarm = ringing & tone_in;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed testbench for alarm_unit with default parameters.
module tb_alarm_unit;

  logic        cp = 1'b0;
  logic        rst;
  logic        sec_tick;
  logic [23:0] hms;
  logic        tone_in;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [15:0] wr_hm;
  logic        wr_on;
  logic        stop;
  logic        snooze;
  logic        alarm;
  logic        ringing;
  logic        snoozing;
  logic [1:0]  active_idx;
  logic [3:0]  alarm_on;

  int total = 0;
  int bad   = 0;

  alarm_unit #(.NUM_ALARMS(4), .RING_SECS(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .cp(cp), .rst(rst), .sec_tick(sec_tick), .hms(hms), .tone_in(tone_in),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hm(wr_hm), .wr_on(wr_on),
    .stop(stop), .snooze(snooze), .alarm(alarm), .ringing(ringing),
    .snoozing(snoozing), .active_idx(active_idx), .alarm_on(alarm_on)
  );

  always #5 cp = ~cp;

  task automatic write_ch(input logic [1:0] idx, input logic [15:0] hm, input logic on);
    @(negedge cp); wr_en = 1'b1; wr_idx = idx; wr_hm = hm; wr_on = on;
    @(negedge cp); wr_en = 1'b0;
  endtask

  task automatic tick(input logic [23:0] t);
    @(negedge cp); hms = t; sec_tick = 1'b1;
    @(negedge cp); sec_tick = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge cp); stop = 1'b1;
    @(negedge cp); stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    @(negedge cp); snooze = 1'b1;
    @(negedge cp); snooze = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge cp); rst = 1'b1;
    @(negedge cp); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tone_in = 1'b1;
    repeat (2) @(negedge cp);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL reset_ringing got=%b exp=0", ringing); end
    total++; if (snoozing !== 1'b0) begin bad++; $display("FAIL reset_snoozing got=%b exp=0", snoozing); end
    total++; if (active_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", active_idx); end
    total++; if (alarm_on !== 4'b0000) begin bad++; $display("FAIL reset_alarm_on got=%b exp=0000", alarm_on); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    rst = 1'b0;
  endtask

  task automatic test_single_hit();
    write_ch(2'd1, 16'h0830, 1'b1);
    total++; if (alarm_on !== 4'b0010) begin bad++; $display("FAIL wr_alarm_on got=%b exp=0010", alarm_on); end
    tick(24'h082959);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL early_ring got=%b exp=0", ringing); end
    tick(24'h083000);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL hit_ring got=%b exp=1", ringing); end
    total++; if (active_idx !== 2'd1) begin bad++; $display("FAIL hit_idx got=%0d exp=1", active_idx); end
    tone_in = 1'b1; #1;
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL tone_hi got=%b exp=1", alarm); end
    tone_in = 1'b0; #1;
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL tone_lo got=%b exp=0", alarm); end
    tone_in = 1'b1;
    write_ch(2'd3, 16'h1200, 1'b1);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL wr_disturb got=%b exp=1", ringing); end
    total++; if (alarm_on !== 4'b1010) begin bad++; $display("FAIL wr_alarm_on2 got=%b exp=1010", alarm_on); end
    pulse_stop();
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL stop_ring got=%b exp=0", ringing); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL stop_alarm got=%b exp=0", alarm); end
  endtask

  task automatic test_priority();
    do_reset();
    write_ch(2'd0, 16'h0700, 1'b1);
    write_ch(2'd2, 16'h0700, 1'b1);
    tick(24'h070000);
    total++; if (active_idx !== 2'd0) begin bad++; $display("FAIL prio_idx0 got=%0d exp=0", active_idx); end
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL prio_ring0 got=%b exp=1", ringing); end
    pulse_stop();
    write_ch(2'd0, 16'h0700, 1'b0);
    total++; if (alarm_on !== 4'b0100) begin bad++; $display("FAIL prio_on got=%b exp=0100", alarm_on); end
    tick(24'h070000);
    total++; if (active_idx !== 2'd2) begin bad++; $display("FAIL prio_idx2 got=%0d exp=2", active_idx); end
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL prio_ring2 got=%b exp=1", ringing); end
    pulse_stop();
  endtask

  task automatic test_timeout();
    write_ch(2'd3, 16'h0701, 1'b1);
    tick(24'h070000);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL to_start got=%b exp=1", ringing); end
    for (int k = 1; k <= 59; k++) tick((k == 30) ? 24'h070100 : 24'h070001);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL to_59 got=%b exp=1", ringing); end
    total++; if (active_idx !== 2'd2) begin bad++; $display("FAIL to_lost_hit got=%0d exp=2", active_idx); end
    tick(24'h070001);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL to_60 got=%b exp=0", ringing); end
    tick(24'h070002);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL to_after got=%b exp=0", ringing); end
  endtask

  task automatic test_snooze();
    do_reset();
    write_ch(2'd1, 16'h0830, 1'b1);
    tick(24'h083000);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL snz_start got=%b exp=1", ringing); end
`ifdef ALARM_SNOOZE_EN
    for (int s = 1; s <= 3; s++) begin
      pulse_snooze();
      total++; if (snoozing !== 1'b1 || ringing !== 1'b0) begin bad++; $display("FAIL snz_enter%0d got=%b%b exp=10", s, snoozing, ringing); end
      for (int k = 0; k < 299; k++) tick(24'h083001);
      total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL snz_299_%0d got=%b exp=1", s, snoozing); end
      tick(24'h083001);
      total++; if (ringing !== 1'b1 || snoozing !== 1'b0) begin bad++; $display("FAIL snz_wake%0d got=%b%b exp=10", s, ringing, snoozing); end
    end
    pulse_snooze();
    total++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin bad++; $display("FAIL snz_fourth got=%b%b exp=00", ringing, snoozing); end
    write_ch(2'd2, 16'h0840, 1'b1);
    tick(24'h083000);
    pulse_snooze();
    tick(24'h084000);
    total++; if (ringing !== 1'b1 || active_idx !== 2'd2) begin bad++; $display("FAIL snz_preempt got=%b/%0d exp=1/2", ringing, active_idx); end
    pulse_snooze();
    pulse_stop();
    total++; if (snoozing !== 1'b0 || ringing !== 1'b0) begin bad++; $display("FAIL snz_stop got=%b%b exp=00", snoozing, ringing); end
`else
    pulse_snooze();
    total++; if (ringing !== 1'b1 || snoozing !== 1'b0) begin bad++; $display("FAIL snz_ignored got=%b%b exp=10", ringing, snoozing); end
    pulse_stop();
`endif
  endtask

  task automatic test_stop_snooze();
    do_reset();
    write_ch(2'd1, 16'h0830, 1'b1);
    tick(24'h083000);
    @(negedge cp); stop = 1'b1; snooze = 1'b1;
    @(negedge cp); stop = 1'b0; snooze = 1'b0;
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL ss_ring got=%b exp=0", ringing); end
    total++; if (snoozing !== 1'b0) begin bad++; $display("FAIL ss_snz got=%b exp=0", snoozing); end
    @(negedge cp);
    total++; if (snoozing !== 1'b0) begin bad++; $display("FAIL ss_snz2 got=%b exp=0", snoozing); end
  endtask

  task automatic test_reset_mid();
    tick(24'h083000);
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL rm_ring got=%b exp=1", ringing); end
    #2 rst = 1'b1;
    #1;
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL rm_async_ring got=%b exp=0", ringing); end
    total++; if (alarm_on !== 4'b0000) begin bad++; $display("FAIL rm_async_on got=%b exp=0000", alarm_on); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL rm_async_alarm got=%b exp=0", alarm); end
    @(negedge cp); rst = 1'b0;
    tick(24'h083000);
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL rm_no_ring got=%b exp=0", ringing); end
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; hms = '0; tone_in = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_hm = '0; wr_on = 1'b0;
    stop = 1'b0; snooze = 1'b0;
    test_reset();
    test_single_hit();
    test_priority();
    test_timeout();
    test_snooze();
    test_stop_snooze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
